// File: rtl/sgpr_pkg.sv
// Shared sizing defaults and the pipe stage record for the SGPR SIMD/SIMF write path.
package sgpr_pkg;

   localparam int SGPR_ADDR_W         = 9;
   localparam int SGPR_DATA_W         = 64;
   localparam int SGPR_NUM_SIMX_PORTS = 8;

   // One in-flight masked write as it travels down the read-modify-write pipe.
   typedef struct packed {
      logic                   vld;
      logic [SGPR_ADDR_W-1:0] addr;
      logic [SGPR_DATA_W-1:0] data;
      logic [SGPR_DATA_W-1:0] mask;
   } sgpr_stage_t;

endpackage

// File: rtl/sgpr_rr_arbiter.sv
// Round-robin arbiter: one-hot grant to the first requester at or after the pointer.
// The pointer moves to one past the winner, so a port only wins twice in a row when alone.
module sgpr_rr_arbiter
   import sgpr_pkg::*;
#(
   parameter int NUM_PORTS = SGPR_NUM_SIMX_PORTS,
   localparam int PTR_W    = $clog2(NUM_PORTS)
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [NUM_PORTS-1:0] req,
   output logic [NUM_PORTS-1:0] grant,
   output logic                 grant_any,
   output logic [PTR_W-1:0]     grant_idx
);

   logic [PTR_W-1:0] ptr;

   // Search the requesters in rotated order starting at the pointer; nothing is granted in reset.
   always_comb begin
      grant     = '0;
      grant_any = 1'b0;
      grant_idx = '0;
      for (int i = 0; i < NUM_PORTS; i++) begin
         if (!grant_any && !rst && req[(int'(ptr) + i) % NUM_PORTS]) begin
            grant_any = 1'b1;
            grant_idx = PTR_W'((int'(ptr) + i) % NUM_PORTS);
         end
      end
      if (grant_any) grant[grant_idx] = 1'b1;
   end

   // Advance the pointer past the winner; hold it when nobody asks.
   always_ff @(posedge clk) begin
      if (rst) begin
         ptr <= '0;
      end else if (grant_any) begin
         ptr <= (int'(grant_idx) == NUM_PORTS - 1) ? '0 : grant_idx + PTR_W'(1);
      end
   end

endmodule

// File: rtl/sgpr_simx_rmw_wr_pipe.sv
// Pipelined masked SGPR write port: arbitrate (S0), issue RF read (S1), merge with
// forwarding (S2), write to RF (S3). W keeps the previous write for one more cycle
// because the RF returns old data when read and write hit the same entry together.
module sgpr_simx_rmw_wr_pipe
   import sgpr_pkg::*;
#(
   parameter int NUM_PORTS = SGPR_NUM_SIMX_PORTS,
   parameter int ADDR_W    = SGPR_ADDR_W,
   parameter int DATA_W    = SGPR_DATA_W
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic [NUM_PORTS-1:0]        req_valid,
   output logic [NUM_PORTS-1:0]        req_ready,
   input  logic [NUM_PORTS*ADDR_W-1:0] req_addr,
   input  logic [NUM_PORTS*DATA_W-1:0] req_data,
   input  logic [NUM_PORTS*DATA_W-1:0] req_mask,
   output logic [ADDR_W-1:0]           rf_rd_addr,
   input  logic [DATA_W-1:0]           rf_rd_data,
   output logic                        rf_wr_en,
   output logic [ADDR_W-1:0]           rf_wr_addr,
   output logic [DATA_W-1:0]           rf_wr_data,
   output logic                        issue_valu_dest_reg_valid,
   output logic [ADDR_W-1:0]           issue_valu_dest_addr,
   output logic                        busy
);

   localparam int PTR_W = $clog2(NUM_PORTS);

   function automatic logic [DATA_W-1:0] rmw_merge(input logic [DATA_W-1:0] new_d,
                                                   input logic [DATA_W-1:0] mask,
                                                   input logic [DATA_W-1:0] old_d);
      return (new_d & mask) | (old_d & ~mask);
   endfunction

   logic                 grant_any;
   logic [PTR_W-1:0]     grant_idx;
   logic [ADDR_W-1:0]    addr_p0;
   logic [DATA_W-1:0]    data_p0, mask_p0;
   logic                 vld_p1, vld_p2, vld_p4;
   logic [ADDR_W-1:0]    addr_p1, addr_p2, addr_p4;
   logic [DATA_W-1:0]    data_p1, mask_p1, data_p2, mask_p2, data_p4;
   logic [DATA_W-1:0]    old_p2, merged_p2;

   sgpr_rr_arbiter #(.NUM_PORTS(NUM_PORTS)) u_arb (
      .clk       (clk),
      .rst       (rst),
      .req       (req_valid),
      .grant     (req_ready),
      .grant_any (grant_any),
      .grant_idx (grant_idx)
   );

   // S0: pick the granted port's payload.
   always_comb begin
      addr_p0 = req_addr[int'(grant_idx)*ADDR_W +: ADDR_W];
      data_p0 = req_data[int'(grant_idx)*DATA_W +: DATA_W];
      mask_p0 = req_mask[int'(grant_idx)*DATA_W +: DATA_W];
   end

   // S0 -> S1: capture the accepted request; its address drives the RF read port.
   always_ff @(posedge clk) begin
      if (rst) begin
         vld_p1  <= 1'b0;
         addr_p1 <= '0;
         data_p1 <= '0;
         mask_p1 <= '0;
      end else begin
         vld_p1  <= grant_any;
         addr_p1 <= addr_p0;
         data_p1 <= data_p0;
         mask_p1 <= mask_p0;
      end
   end

   assign rf_rd_addr = addr_p1;

   // S1 -> S2: RF read data lines up with this stage.
   always_ff @(posedge clk) begin
      if (rst) begin
         vld_p2  <= 1'b0;
         addr_p2 <= '0;
         data_p2 <= '0;
         mask_p2 <= '0;
      end else begin
         vld_p2  <= vld_p1;
         addr_p2 <= addr_p1;
         data_p2 <= data_p1;
         mask_p2 <= mask_p1;
      end
   end

   // S2: choose the youngest copy of the target register, then merge under the mask.
   always_comb begin
      if (rf_wr_en && rf_wr_addr == addr_p2) begin
         old_p2 = rf_wr_data;
      end else if (vld_p4 && addr_p4 == addr_p2) begin
         old_p2 = data_p4;
      end else begin
         old_p2 = rf_rd_data;
      end
      merged_p2 = rmw_merge(data_p2, mask_p2, old_p2);
   end

   // S2 -> S3: registered RF write; it lands at the end of this cycle.
   always_ff @(posedge clk) begin
      if (rst) begin
         rf_wr_en   <= 1'b0;
         rf_wr_addr <= '0;
         rf_wr_data <= '0;
      end else begin
         rf_wr_en   <= vld_p2;
         rf_wr_addr <= addr_p2;
         rf_wr_data <= merged_p2;
      end
   end

   // S3 -> W: remember the write the RF is committing so the next read can be corrected.
   always_ff @(posedge clk) begin
      if (rst) begin
         vld_p4  <= 1'b0;
         addr_p4 <= '0;
         data_p4 <= '0;
      end else begin
         vld_p4  <= rf_wr_en;
         addr_p4 <= rf_wr_addr;
         data_p4 <= rf_wr_data;
      end
   end

   assign issue_valu_dest_reg_valid = rf_wr_en;
   assign issue_valu_dest_addr      = rf_wr_addr;
   assign busy                      = vld_p1 | vld_p2 | rf_wr_en;

endmodule

// File: tb/tb_sgpr_simx_rmw_wr_pipe.sv
// Bench for sgpr_simx_rmw_wr_pipe: RF behavioural model, reference memory with a pending-write
// list, and scenario tasks covering arbitration, merging, forwarding and reset.
module tb_sgpr_simx_rmw_wr_pipe;

   localparam int NP = 8;
   localparam int AW = 9;
   localparam int DW = 64;

   logic             clk = 1'b0;
   logic             rst;
   logic [NP-1:0]    req_valid, req_ready;
   logic [NP*AW-1:0] req_addr;
   logic [NP*DW-1:0] req_data, req_mask;
   logic [AW-1:0]    rf_rd_addr, rf_wr_addr, issue_valu_dest_addr;
   logic [DW-1:0]    rf_rd_data, rf_wr_data;
   logic             rf_wr_en, issue_valu_dest_reg_valid, busy;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;

   sgpr_simx_rmw_wr_pipe #(.NUM_PORTS(NP), .ADDR_W(AW), .DATA_W(DW)) dut (
      .clk                       (clk),
      .rst                       (rst),
      .req_valid                 (req_valid),
      .req_ready                 (req_ready),
      .req_addr                  (req_addr),
      .req_data                  (req_data),
      .req_mask                  (req_mask),
      .rf_rd_addr                (rf_rd_addr),
      .rf_rd_data                (rf_rd_data),
      .rf_wr_en                  (rf_wr_en),
      .rf_wr_addr                (rf_wr_addr),
      .rf_wr_data                (rf_wr_data),
      .issue_valu_dest_reg_valid (issue_valu_dest_reg_valid),
      .issue_valu_dest_addr      (issue_valu_dest_addr),
      .busy                      (busy)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Register file: synchronous read returning old data on read-during-write, plus a preload port.
   logic [DW-1:0] rf_mem [0:(1<<AW)-1] = '{default: '0};
   logic          pl_en = 1'b0;
   logic [AW-1:0] pl_a  = '0;
   logic [DW-1:0] pl_d  = '0;
   always @(posedge clk) begin
      rf_rd_data <= rf_mem[rf_rd_addr];
      if (pl_en) rf_mem[pl_a] <= pl_d;
      else if (rf_wr_en) rf_mem[rf_wr_addr] <= rf_wr_data;
   end

   // Requester state.
   logic [NP-1:0] pv;
   logic [AW-1:0] pa [NP];
   logic [DW-1:0] pd [NP];
   logic [DW-1:0] pm [NP];

   // Reference: committed memory plus the ordered list of accepted writes not yet due.
   typedef struct {
      logic [AW-1:0] a;
      logic [DW-1:0] d;
      int            due;
   } wr_t;
   logic [DW-1:0] ref_mem [0:(1<<AW)-1] = '{default: '0};
   wr_t           expq[$];
   int            mptr = 0;
   logic [NP-1:0] e_gnt;
   logic          e_wen, e_busy;
   logic [AW-1:0] e_waddr;
   logic [DW-1:0] e_wdata;
   int            e_port;

   task automatic drive();
      for (int p = 0; p < NP; p++) begin
         req_addr[p*AW +: AW] = pa[p];
         req_data[p*DW +: DW] = pd[p];
         req_mask[p*DW +: DW] = pm[p];
      end
      req_valid = pv;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic new_payload(input int p, input int amax);
      pa[p] = AW'($urandom_range(amax));
      pd[p] = {$urandom, $urandom};
      case ($urandom_range(3))
         0:       pm[p] = '0;
         1:       pm[p] = '1;
         default: pm[p] = {$urandom, $urandom};
      endcase
   endtask

   task automatic preload(input logic [AW-1:0] a, input logic [DW-1:0] v);
      pl_a = a; pl_d = v; pl_en = 1'b1;
      ref_mem[a] = v;
      step();
      pl_en = 1'b0;
   endtask

   // Settle, then work out what this cycle must show and what the current handshake commits to.
   task automatic advance();
      logic [DW-1:0] old;
      wr_t           w;
      #1;
      e_gnt = '0; e_port = -1; e_wen = 1'b0; e_waddr = '0; e_wdata = '0; e_busy = 1'b0;
      foreach (expq[i]) if (expq[i].due <= cyc + 2) e_busy = 1'b1;
      if (expq.size() > 0 && expq[0].due == cyc) begin
         w = expq.pop_front();
         e_wen = 1'b1; e_waddr = w.a; e_wdata = w.d;
         ref_mem[w.a] = w.d;
      end
      if (rst) begin
         expq.delete();
         mptr = 0;
      end else if (req_valid != '0) begin
         for (int i = 0; i < NP; i++)
            if (e_port < 0 && req_valid[(mptr + i) % NP]) e_port = (mptr + i) % NP;
         e_gnt[e_port] = 1'b1;
         mptr = (e_port + 1) % NP;
         old = ref_mem[pa[e_port]];
         foreach (expq[i]) if (expq[i].a == pa[e_port]) old = expq[i].d;
         w.a = pa[e_port];
         w.d = (pd[e_port] & pm[e_port]) | (old & ~pm[e_port]);
         w.due = cyc + 3;
         expq.push_back(w);
      end
   endtask

   task automatic do_reset();
      rst = 1'b1;
      drive();
      advance();
      step();
      rst = 1'b0;
   endtask

   task automatic test_reset();
      pv = '1;
      for (int c = 0; c < 2; c++) begin
         step();
         drive();
         advance();
         checks++; if (req_ready !== '0) begin errors++; $display("FAIL reset_ready: got %b want 0", req_ready); end
         checks++; if (rf_wr_en !== 1'b0) begin errors++; $display("FAIL reset_wr_en: got %b want 0", rf_wr_en); end
         checks++; if (issue_valu_dest_reg_valid !== 1'b0) begin errors++; $display("FAIL reset_issue: got %b want 0", issue_valu_dest_reg_valid); end
         checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
      end
      step();
      rst = 1'b0;
      pv  = '0;
      drive();
      step();
   endtask

   task automatic test_single();
      preload(9'h010, 64'hFFFF_0000_FFFF_0000);
      pv = '0; pv[3] = 1'b1;
      pa[3] = 9'h010; pd[3] = 64'h1234_5678_9ABC_DEF0; pm[3] = 64'h0000_0000_FFFF_FFFF;
      for (int c = 0; c < 6; c++) begin
         drive();
         advance();
         checks++; if (req_ready !== e_gnt) begin errors++; $display("FAIL single_grant: cyc %0d got %b want %b", cyc, req_ready, e_gnt); end
         checks++; if (rf_wr_en !== e_wen || (e_wen && (rf_wr_addr !== e_waddr || rf_wr_data !== e_wdata))) begin errors++; $display("FAIL single_write: cyc %0d got %b %h %h want %b %h %h", cyc, rf_wr_en, rf_wr_addr, rf_wr_data, e_wen, e_waddr, e_wdata); end
         checks++; if (busy !== e_busy) begin errors++; $display("FAIL single_busy: cyc %0d got %b want %b", cyc, busy, e_busy); end
         if (c == 0) begin
            checks++; if (req_ready !== 8'b0000_1000) begin errors++; $display("FAIL single_port3: got %b want 00001000", req_ready); end
         end
         if (c == 3) begin
            checks++;
            if (rf_wr_en !== 1'b1 || rf_wr_addr !== 9'h010 || rf_wr_data !== 64'hFFFF_0000_9ABC_DEF0 ||
                issue_valu_dest_reg_valid !== 1'b1 || issue_valu_dest_addr !== 9'h010) begin
               errors++; $display("FAIL single_n3: got en %b addr %h data %h issue %b/%h want 1 010 ffff00009abcdef0 1/010", rf_wr_en, rf_wr_addr, rf_wr_data, issue_valu_dest_reg_valid, issue_valu_dest_addr);
            end
         end
         if (e_port >= 0) pv[e_port] = 1'b0;
         step();
      end
   endtask

   task automatic test_b2b();
      logic [DW-1:0] mt [3];
      logic [DW-1:0] wt [3];
      int nacc = 0;
      mt[0] = 64'hFF; mt[1] = 64'hFF00; mt[2] = 64'hFF_0000;
      wt[0] = 64'hFF; wt[1] = 64'hFFFF; wt[2] = 64'hFF_FFFF;
      preload(9'h020, '0);
      pa[6] = 9'h020; pd[6] = '1;
      for (int c = 0; c < 7; c++) begin
         pv = '0;
         if (nacc < 3) begin pv[6] = 1'b1; pm[6] = mt[nacc]; end
         drive();
         advance();
         checks++; if (req_ready !== e_gnt) begin errors++; $display("FAIL b2b_grant: cyc %0d got %b want %b", cyc, req_ready, e_gnt); end
         checks++; if (rf_wr_en !== e_wen || (e_wen && (rf_wr_addr !== e_waddr || rf_wr_data !== e_wdata))) begin errors++; $display("FAIL b2b_write: cyc %0d got %b %h %h want %b %h %h", cyc, rf_wr_en, rf_wr_addr, rf_wr_data, e_wen, e_waddr, e_wdata); end
         checks++; if (busy !== e_busy) begin errors++; $display("FAIL b2b_busy: cyc %0d got %b want %b", cyc, busy, e_busy); end
         if (c >= 3 && c <= 5) begin
            checks++;
            if (rf_wr_en !== 1'b1 || rf_wr_addr !== 9'h020 || rf_wr_data !== wt[c-3]) begin
               errors++; $display("FAIL b2b_value: step %0d got %b %h %h want 1 020 %h", c, rf_wr_en, rf_wr_addr, rf_wr_data, wt[c-3]);
            end
         end
         if (e_port == 6) nacc++;
         step();
      end
   endtask

   task automatic test_all_ports();
      pv = '1;
      for (int p = 0; p < NP; p++) new_payload(p, 3);
      do_reset();
      for (int c = 0; c < 22; c++) begin
         drive();
         advance();
         checks++; if (req_ready !== e_gnt) begin errors++; $display("FAIL all_grant: cyc %0d got %b want %b", cyc, req_ready, e_gnt); end
         checks++; if (rf_wr_en !== e_wen || (e_wen && (rf_wr_addr !== e_waddr || rf_wr_data !== e_wdata))) begin errors++; $display("FAIL all_write: cyc %0d got %b %h %h want %b %h %h", cyc, rf_wr_en, rf_wr_addr, rf_wr_data, e_wen, e_waddr, e_wdata); end
         checks++; if (busy !== e_busy) begin errors++; $display("FAIL all_busy: cyc %0d got %b want %b", cyc, busy, e_busy); end
         if (c < 9) begin
            checks++; if (req_ready !== NP'(1) << (c % NP)) begin errors++; $display("FAIL all_order: step %0d got %b want port %0d", c, req_ready, c % NP); end
         end
         if (e_port >= 0) begin
            if (c < 9) new_payload(e_port, 3);
            else pv[e_port] = 1'b0;
         end
         step();
      end
   endtask

   task automatic test_two_ports();
      int seq [4];
      int cnt [NP];
      seq[0] = 2; seq[1] = 5; seq[2] = 2; seq[3] = 5;
      for (int p = 0; p < NP; p++) cnt[p] = 0;
      pv = '0;
      do_reset();
      pv[2] = 1'b1; pv[5] = 1'b1;
      new_payload(2, 15); new_payload(5, 15);
      for (int c = 0; c < 8; c++) begin
         drive();
         advance();
         checks++; if (req_ready !== e_gnt) begin errors++; $display("FAIL two_grant: cyc %0d got %b want %b", cyc, req_ready, e_gnt); end
         checks++; if (rf_wr_en !== e_wen || (e_wen && (rf_wr_addr !== e_waddr || rf_wr_data !== e_wdata))) begin errors++; $display("FAIL two_write: cyc %0d got %b %h %h want %b %h %h", cyc, rf_wr_en, rf_wr_addr, rf_wr_data, e_wen, e_waddr, e_wdata); end
         if (c < 4) begin
            checks++; if (req_ready !== NP'(1) << seq[c]) begin errors++; $display("FAIL two_order: step %0d got %b want port %0d", c, req_ready, seq[c]); end
         end
         if (e_port >= 0) begin
            cnt[e_port]++;
            if (cnt[e_port] < 2) new_payload(e_port, 15);
            else pv[e_port] = 1'b0;
         end
         step();
      end
   endtask

   task automatic test_mask_zero();
      preload(9'h1FF, 64'hA5);
      pv = '0; pv[0] = 1'b1;
      pa[0] = 9'h1FF; pd[0] = {$urandom, $urandom}; pm[0] = '0;
      for (int c = 0; c < 5; c++) begin
         drive();
         advance();
         checks++; if (req_ready !== e_gnt) begin errors++; $display("FAIL mask0_grant: cyc %0d got %b want %b", cyc, req_ready, e_gnt); end
         checks++; if (rf_wr_en !== e_wen || (e_wen && (rf_wr_addr !== e_waddr || rf_wr_data !== e_wdata))) begin errors++; $display("FAIL mask0_write: cyc %0d got %b %h %h want %b %h %h", cyc, rf_wr_en, rf_wr_addr, rf_wr_data, e_wen, e_waddr, e_wdata); end
         if (c == 3) begin
            checks++;
            if (rf_wr_en !== 1'b1 || rf_wr_data !== 64'hA5 || issue_valu_dest_reg_valid !== 1'b1 || issue_valu_dest_addr !== 9'h1FF) begin
               errors++; $display("FAIL mask0_value: got en %b data %h issue %b/%h want 1 a5 1/1ff", rf_wr_en, rf_wr_data, issue_valu_dest_reg_valid, issue_valu_dest_addr);
            end
         end
         if (e_port >= 0) pv[e_port] = 1'b0;
         step();
      end
   endtask

   task automatic test_rst_midflight();
      pv = '1;
      for (int p = 0; p < NP; p++) new_payload(p, 7);
      for (int c = 0; c < 18; c++) begin
         rst = (c == 3);
         drive();
         advance();
         checks++; if (req_ready !== e_gnt) begin errors++; $display("FAIL rst_grant: cyc %0d got %b want %b", cyc, req_ready, e_gnt); end
         checks++; if (rf_wr_en !== e_wen || (e_wen && (rf_wr_addr !== e_waddr || rf_wr_data !== e_wdata))) begin errors++; $display("FAIL rst_write: cyc %0d got %b %h %h want %b %h %h", cyc, rf_wr_en, rf_wr_addr, rf_wr_data, e_wen, e_waddr, e_wdata); end
         checks++; if (busy !== e_busy) begin errors++; $display("FAIL rst_busy: cyc %0d got %b want %b", cyc, busy, e_busy); end
         if (c == 3) begin
            checks++; if (req_ready !== '0) begin errors++; $display("FAIL rst_hold_ready: got %b want 0", req_ready); end
         end
         if (c >= 4 && c <= 6) begin
            checks++; if (rf_wr_en !== 1'b0) begin errors++; $display("FAIL rst_dropped: step %0d got wr_en %b want 0", c, rf_wr_en); end
         end
         if (c == 4) begin
            checks++; if (busy !== 1'b0 || req_ready !== 8'b0000_0001) begin errors++; $display("FAIL rst_restart: got busy %b grant %b want 0 00000001", busy, req_ready); end
         end
         if (e_port >= 0) begin
            if (c < 3) new_payload(e_port, 7);
            else pv[e_port] = 1'b0;
         end
         step();
      end
      rst = 1'b0;
   endtask

   task automatic test_random();
      pv = '0;
      for (int c = 0; c < 400; c++) begin
         for (int p = 0; p < NP; p++) begin
            if (!pv[p] && c < 380 && $urandom_range(2) == 0) begin
               pv[p] = 1'b1;
               new_payload(p, 7);
            end
         end
         drive();
         advance();
         checks++; if (req_ready !== e_gnt) begin errors++; $display("FAIL rand_grant: cyc %0d got %b want %b", cyc, req_ready, e_gnt); end
         checks++; if (rf_wr_en !== e_wen || (e_wen && (rf_wr_addr !== e_waddr || rf_wr_data !== e_wdata))) begin errors++; $display("FAIL rand_write: cyc %0d got %b %h %h want %b %h %h", cyc, rf_wr_en, rf_wr_addr, rf_wr_data, e_wen, e_waddr, e_wdata); end
         checks++; if (issue_valu_dest_reg_valid !== e_wen || (e_wen && issue_valu_dest_addr !== e_waddr)) begin errors++; $display("FAIL rand_issue: cyc %0d got %b %h want %b %h", cyc, issue_valu_dest_reg_valid, issue_valu_dest_addr, e_wen, e_waddr); end
         checks++; if (busy !== e_busy) begin errors++; $display("FAIL rand_busy: cyc %0d got %b want %b", cyc, busy, e_busy); end
         if (e_port >= 0) pv[e_port] = 1'b0;
         step();
      end
      checks++; if (expq.size() != 0 || pv != '0) begin errors++; $display("FAIL rand_drain: pending %0d valid %b want 0 0", expq.size(), pv); end
   endtask

   initial begin
      rst = 1'b1;
      pv  = '0;
      for (int p = 0; p < NP; p++) begin
         pa[p] = '0; pd[p] = '0; pm[p] = '0;
      end
      drive();
      test_reset();
      test_single();
      test_b2b();
      test_all_ports();
      test_two_ports();
      test_mask_zero();
      test_rst_midflight();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
